ajc_lcd_status_writer: RTL and testbench
========================================

Name: ajc_lcd_status_writer

Overview:
- Downstream consumer of the CPU top level.
- Takes the 12-character ASCII instruction mnemonic (ICis) and the current micro-cycle index (crtMCis), and drives an HD44780-compatible 16x2 character LCD in 8-bit write-only mode.
- Performs the power-up init sequence, then rewrites the display whenever the displayed status changes.

Parameters:
- T_PWRUP, 750000: cycles to wait after reset before the first command (15 ms at 50 MHz).
- T_EN, 25: cycles LCD_EN is held high per byte.
- T_CMD, 2000: post-byte wait cycles for ordinary commands and data.
- T_CLR, 82000: post-byte wait cycles after the clear command 0x01.

Ports:
- Clock  in  1  system clock
- Reset  in  1  asynchronous, active-low reset
- ICis  in  96  12 ASCII chars; [95:88] is the leftmost character
- crtMCis  in  3  current micro-cycle index 0..7
- LCD_DATA  out  8  LCD data bus
- LCD_RS  out  1  0 = command, 1 = data
- LCD_RW  out  1  tied 0 (write only)
- LCD_EN  out  1  LCD enable strobe
- LCD_ON  out  1  LCD power enable
- Ready  out  1  init sequence complete
- Busy  out  1  refresh in progress

Behaviour:
- Reset values (Reset=0, asynchronous): LCD_DATA=0, LCD_RS=0, LCD_RW=0, LCD_EN=0, LCD_ON=0, Ready=0, Busy=0. All counters and states are cleared and the snapshot is invalidated.
- LCD_ON goes to 1 on the first clock after reset release. LCD_RW is always 0.
- Byte-write sub-sequence, fixed for every byte:
  - SETUP: 1 cycle. LCD_DATA and LCD_RS are loaded; LCD_EN=0.
  - EN_HI: T_EN cycles with LCD_EN=1.
  - HOLD: 1 cycle with LCD_EN=0.
  - WAIT: T_CLR cycles if the byte was command 0x01, otherwise T_CMD cycles.
  - Total per byte = 2 + T_EN + wait.
  - LCD_DATA and LCD_RS change only in SETUP and are stable through HOLD and WAIT.
- Top FSM states: PWRUP → INIT → IDLE → SNAP → L1ADDR → L1CHR → L2ADDR → L2CHR → IDLE.
- PWRUP: counts T_PWRUP cycles, then goes to INIT.
- INIT: writes commands 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 in order (RS=0). After the WAIT of the last command, Ready=1 and the FSM goes to IDLE. Ready stays high until reset.
- IDLE: compares {ICis, crtMCis} with the last-written snapshot. If they differ, or the snapshot is invalid, the FSM goes to SNAP. Otherwise it stays in IDLE.
- SNAP: captures {ICis, crtMCis} into the snapshot register and sets Busy=1. The inputs are sampled only in this cycle.
- L1ADDR: writes command 0x80.
- L1CHR: writes 12 data bytes (RS=1) from the snapshot, MSB byte first. Any byte < 0x20 or > 0x7E is written as 0x20.
- L2ADDR: writes command 0xC0.
- L2CHR: writes 4 data bytes: 0x4D 'M', 0x43 'C', 0x3A ':', then 0x30 + crtMCis snapshot.
- After the last WAIT of L2CHR, the snapshot is marked valid, Busy=0 and the FSM goes to IDLE.
- A refresh is exactly 18 byte writes.
- Input change mid-refresh: no effect on bytes already in progress. Detection happens in IDLE after completion, giving exactly one more refresh with the new values.
- Reset mid-byte: LCD_EN drops immediately (asynchronous). The full PWRUP and INIT sequence is repeated.
- Counters are sized with $clog2 of the largest parameter + 1. The character index is 4 bits and is bounded by 11 or 3; it never wraps past these bounds.

Optional Feature:
- Macro: AJC_LCD_ALWAYS_REFRESH_EN.
- Defined: IDLE goes straight to SNAP every time, with no compare. Refreshes are back-to-back, with exactly 1 IDLE cycle between them.
- Undefined: change-detect behaviour as above; the snapshot comparator is present.

Decomposition:
- Package ajc_lcd_pkg holds:
  - Command constants: CMD_FUNC 0x38, CMD_DISP 0x0C, CMD_CLR 0x01, CMD_ENTRY 0x06, CMD_L1 0x80, CMD_L2 0xC0.
  - ASCII_SPACE 0x20.
  - Top-FSM and byte-FSM state encodings.
- Sub-module ajc_lcd_byte_tx implements the byte-write sub-sequence:
  - Inputs: start, data, rs, long_wait.
  - Outputs: done pulse, LCD_DATA, LCD_RS, LCD_EN.
  - The top FSM only sequences bytes.

Test Plan:
All scenarios use T_PWRUP=10, T_EN=2, T_CMD=4, T_CLR=8.
1. Release Reset → after 10 cycles, 6 EN pulses of 2 cycles each with RS=0 and data 38,38,38,0C,01,06. The gap after 01 is 8 wait cycles. Ready rises after the final wait.
2. ICis="ADD R0,R1   ", crtMCis=3 → bytes 80, then 41 44 44 20 52 30 2C 52 31 20 20 20 (RS=1), then C0, then 4D 43 3A 33 (RS=1). Exactly 18 EN pulses; Busy high for the whole refresh.
3. Inputs held constant for 1000 cycles after a refresh → zero further EN pulses; Busy=0. With AJC_LCD_ALWAYS_REFRESH_EN, refreshes repeat continuously.
4. crtMCis changed 3→5 during byte 7 of a refresh → that refresh ends with 33, then one further refresh ends with 35, then idle.
5. ICis leftmost byte 0x07 and another byte 0x80 → both written as 0x20.
6. Reset asserted while LCD_EN=1 → LCD_EN, Ready and LCD_ON are 0 in the same cycle. After release, the full sequence from scenario 1 repeats, followed by a full refresh.

Source files
------------

// File: rtl/ajc_lcd_pkg.sv
// ajc_lcd_pkg: shared constants, state encodings and helpers for the LCD
// status writer (HD44780 command bytes, top/byte FSM states, printable filter).
package ajc_lcd_pkg;

  localparam logic [7:0] CMD_FUNC    = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] CMD_DISP    = 8'h0C;  // display on, cursor off
  localparam logic [7:0] CMD_CLR     = 8'h01;  // clear display (long execution)
  localparam logic [7:0] CMD_ENTRY   = 8'h06;  // increment, no shift
  localparam logic [7:0] CMD_L1      = 8'h80;  // DDRAM address line 1, col 0
  localparam logic [7:0] CMD_L2      = 8'hC0;  // DDRAM address line 2, col 0
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [2:0] {
    S_PWRUP,
    S_INIT,
    S_IDLE,
    S_SNAP,
    S_L1ADDR,
    S_L1CHR,
    S_L2ADDR,
    S_L2CHR
  } top_state_e;

  typedef enum logic [2:0] {
    B_IDLE,
    B_SETUP,
    B_EN_HI,
    B_HOLD,
    B_WAIT
  } byte_state_e;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Characters outside the printable ASCII range are shown as blanks.
  function automatic logic [7:0] lcd_char(input logic [7:0] c);
    return (c < 8'h20 || c > 8'h7E) ? ASCII_SPACE : c;
  endfunction

endpackage

// File: rtl/ajc_lcd_byte_tx.sv
// ajc_lcd_byte_tx: writes one byte to an HD44780 bus.
// Sequence: SETUP (1) -> EN_HI (T_EN) -> HOLD (1) -> WAIT (T_CLR or T_CMD).
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   start_i                accepted when idle or in the last WAIT cycle
//   data_i, rs_i           byte and register select, latched on start
//   long_wait_i            use T_CLR instead of T_CMD for WAIT
//   done_o                 high during the final WAIT cycle
//   idle_o                 no byte in progress
//   lcd_data_o, lcd_rs_o, lcd_en_o   registered LCD bus outputs
module ajc_lcd_byte_tx
  import ajc_lcd_pkg::*;
#(
  parameter int unsigned T_EN  = 25,
  parameter int unsigned T_CMD = 2000,
  parameter int unsigned T_CLR = 82000,
  parameter int unsigned CW    = 18
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [7:0] data_i,
  input  logic       rs_i,
  input  logic       long_wait_i,
  output logic       done_o,
  output logic       idle_o,
  output logic [7:0] lcd_data_o,
  output logic       lcd_rs_o,
  output logic       lcd_en_o
);

  byte_state_e   st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d, wait_lim;
  logic [7:0]    data_q, data_d;
  logic          rs_q, rs_d, long_q, long_d, en_q, en_d;

  assign wait_lim = long_q ? CW'(T_CLR - 1) : CW'(T_CMD - 1);

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    data_d = data_q;
    rs_d   = rs_q;
    long_d = long_q;
    en_d   = 1'b0;
    done_o = 1'b0;
    case (st_q)
      B_SETUP: begin
        st_d  = B_EN_HI;
        en_d  = 1'b1;
        cnt_d = '0;
      end
      B_EN_HI: begin
        if (cnt_q == CW'(T_EN - 1)) begin
          st_d = B_HOLD;
        end else begin
          en_d  = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      B_HOLD: begin
        st_d  = B_WAIT;
        cnt_d = '0;
      end
      B_WAIT: begin
        if (cnt_q == wait_lim) begin
          done_o = 1'b1;
          st_d   = B_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
    // Accepting a start in the final WAIT cycle keeps bytes back to back.
    if (start_i && (st_q == B_IDLE || done_o)) begin
      st_d   = B_SETUP;
      data_d = data_i;
      rs_d   = rs_i;
      long_d = long_wait_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q   <= B_IDLE;
      cnt_q  <= '0;
      data_q <= '0;
      rs_q   <= 1'b0;
      long_q <= 1'b0;
      en_q   <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      rs_q   <= rs_d;
      long_q <= long_d;
      en_q   <= en_d;
    end
  end

  assign idle_o     = (st_q == B_IDLE);
  assign lcd_data_o = data_q;
  assign lcd_rs_o   = rs_q;
  assign lcd_en_o   = en_q;

endmodule

// File: rtl/ajc_lcd_status_writer.sv
// ajc_lcd_status_writer: drives a 16x2 HD44780 LCD (8-bit, write only) with
// the current instruction mnemonic (line 1) and micro-cycle "MC:n" (line 2).
// Power-up wait, init commands, then a full 18-byte refresh on status change.
// Ports:
//   Clock, Reset (async active-low)
//   ICis[95:0]   12 ASCII chars, [95:88] leftmost
//   crtMCis[2:0] micro-cycle index
//   LCD_DATA, LCD_RS, LCD_RW (always 0), LCD_EN, LCD_ON   LCD interface
//   Ready        init sequence complete; Busy  refresh in progress
// Build option: AJC_LCD_ALWAYS_REFRESH_EN refreshes continuously with no
// change detection.
module ajc_lcd_status_writer
  import ajc_lcd_pkg::*;
#(
  parameter int unsigned T_PWRUP = 750000,
  parameter int unsigned T_EN    = 25,
  parameter int unsigned T_CMD   = 2000,
  parameter int unsigned T_CLR   = 82000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [95:0] ICis,
  input  logic [2:0]  crtMCis,
  output logic [7:0]  LCD_DATA,
  output logic        LCD_RS,
  output logic        LCD_RW,
  output logic        LCD_EN,
  output logic        LCD_ON,
  output logic        Ready,
  output logic        Busy
);

  localparam int unsigned TMAX = max2(max2(T_PWRUP, T_EN), max2(T_CMD, T_CLR));
  localparam int unsigned CW   = $clog2(TMAX) + 1;

  top_state_e    state_q, state_d;
  logic [CW-1:0] pcnt_q, pcnt_d;
  logic [3:0]    idx_q, idx_d;
  logic [95:0]   snap_ic_q;
  logic [2:0]    snap_mc_q;
  logic          snap_ld, valid_q, valid_d, ready_q, ready_d, busy_q, busy_d, on_q;
  logic          refresh_req, tx_start, tx_done, tx_idle, tx_rs, is_write;
  logic [7:0]    tx_byte;
  logic [7:0]    chr [16];

`ifdef AJC_LCD_ALWAYS_REFRESH_EN
  assign refresh_req = 1'b1;
`else
  assign refresh_req = !valid_q || ({ICis, crtMCis} != {snap_ic_q, snap_mc_q});
`endif

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    idx_d   = idx_q;
    snap_ld = 1'b0;
    valid_d = valid_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    case (state_q)
      S_PWRUP: begin
        if (pcnt_q == CW'(T_PWRUP - 1)) begin
          state_d = S_INIT;
          idx_d   = '0;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      S_INIT: if (tx_done) begin
        if (idx_q == 4'd5) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_IDLE: if (refresh_req) state_d = S_SNAP;
      S_SNAP: begin
        snap_ld = 1'b1;
        busy_d  = 1'b1;
        state_d = S_L1ADDR;
      end
      S_L1ADDR: if (tx_done) begin
        state_d = S_L1CHR;
        idx_d   = '0;
      end
      S_L1CHR: if (tx_done) begin
        if (idx_q == 4'd11) state_d = S_L2ADDR;
        else                idx_d   = idx_q + 4'd1;
      end
      S_L2ADDR: if (tx_done) begin
        state_d = S_L2CHR;
        idx_d   = '0;
      end
      S_L2CHR: if (tx_done) begin
        if (idx_q == 4'd3) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          valid_d = 1'b1;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      default: state_d = S_PWRUP;
    endcase
  end

  always_comb begin
    for (int unsigned i = 0; i < 16; i++) chr[i] = ASCII_SPACE;
    for (int unsigned i = 0; i < 12; i++) chr[i] = snap_ic_q[95-8*i -: 8];
  end

  // The byte is selected from the *next* state/index so the following byte
  // can be launched in the final WAIT cycle of the current one.
  always_comb begin
    tx_byte  = '0;
    tx_rs    = 1'b0;
    is_write = 1'b1;
    case (state_d)
      S_INIT: begin
        case (idx_d)
          4'd0, 4'd1, 4'd2: tx_byte = CMD_FUNC;
          4'd3:             tx_byte = CMD_DISP;
          4'd4:             tx_byte = CMD_CLR;
          default:          tx_byte = CMD_ENTRY;
        endcase
      end
      S_L1ADDR: tx_byte = CMD_L1;
      S_L1CHR: begin
        tx_byte = lcd_char(chr[idx_d]);
        tx_rs   = 1'b1;
      end
      S_L2ADDR: tx_byte = CMD_L2;
      S_L2CHR: begin
        tx_rs = 1'b1;
        case (idx_d)
          4'd0:    tx_byte = 8'h4D;
          4'd1:    tx_byte = 8'h43;
          4'd2:    tx_byte = 8'h3A;
          default: tx_byte = 8'h30 + {5'b0, snap_mc_q};
        endcase
      end
      default: is_write = 1'b0;
    endcase
  end

  // Launch on entry into a write state, or chained off the previous byte.
  assign tx_start = is_write && (tx_done || (tx_idle && state_q != state_d));

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_PWRUP;
      pcnt_q    <= '0;
      idx_q     <= '0;
      snap_ic_q <= '0;
      snap_mc_q <= '0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      on_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      on_q    <= 1'b1;
      if (snap_ld) begin
        snap_ic_q <= ICis;
        snap_mc_q <= crtMCis;
      end
    end
  end

  ajc_lcd_byte_tx #(
    .T_EN (T_EN),
    .T_CMD(T_CMD),
    .T_CLR(T_CLR),
    .CW   (CW)
  ) u_byte_tx (
    .clk_i      (Clock),
    .rst_ni     (Reset),
    .start_i    (tx_start),
    .data_i     (tx_byte),
    .rs_i       (tx_rs),
    .long_wait_i(!tx_rs && tx_byte == CMD_CLR),
    .done_o     (tx_done),
    .idle_o     (tx_idle),
    .lcd_data_o (LCD_DATA),
    .lcd_rs_o   (LCD_RS),
    .lcd_en_o   (LCD_EN)
  );

  assign LCD_RW = 1'b0;
  assign LCD_ON = on_q;
  assign Ready  = ready_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_ajc_lcd_status_writer.sv
module tb_ajc_lcd_status_writer;

  localparam int unsigned T_PWRUP = 10;
  localparam int unsigned T_EN    = 2;
  localparam int unsigned T_CMD   = 4;
  localparam int unsigned T_CLR   = 8;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [95:0] ICis = '0;
  logic [2:0]  crtMCis = '0;
  logic [7:0]  LCD_DATA;
  logic        LCD_RS, LCD_RW, LCD_EN, LCD_ON, Ready, Busy;

  int unsigned checks = 0;
  int unsigned failures = 0;

  always #5 Clock = ~Clock;

  ajc_lcd_status_writer #(
    .T_PWRUP(T_PWRUP), .T_EN(T_EN), .T_CMD(T_CMD), .T_CLR(T_CLR)
  ) dut (
    .Clock(Clock), .Reset(Reset), .ICis(ICis), .crtMCis(crtMCis),
    .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN),
    .LCD_ON(LCD_ON), .Ready(Ready), .Busy(Busy)
  );

  // ---------------- bus monitor: one record per EN pulse ----------------
  logic [8:0]  obs_q[$];      // {rs, data} captured at EN rise
  int unsigned gap_q[$];      // low samples before this pulse
  int unsigned width_q[$];    // high samples of this pulse
  int unsigned fall_q[$];     // sample index of EN fall
  logic        busy_at_q[$];  // Busy at EN rise
  int unsigned samp, lo_len, hi_len, rdy_rise, unstable, rw_bad;
  logic        en_prev, rdy_prev;

  always @(negedge Clock) begin
    if (!Reset) begin
      en_prev = 1'b0; rdy_prev = 1'b0; lo_len = 0; hi_len = 0; samp = 0; rdy_rise = 0;
    end else begin
      samp++;
      if (LCD_RW !== 1'b0) rw_bad++;
      if (LCD_EN && !en_prev) begin
        obs_q.push_back({LCD_RS, LCD_DATA});
        gap_q.push_back(lo_len);
        busy_at_q.push_back(Busy);
        hi_len = 1;
      end else if (LCD_EN || en_prev) begin
        if (obs_q.size() > 0 && {LCD_RS, LCD_DATA} !== obs_q[obs_q.size()-1]) unstable++;
        if (LCD_EN) hi_len++;
        else begin
          width_q.push_back(hi_len);
          fall_q.push_back(samp);
          lo_len = 1;
        end
      end else lo_len++;
      if (Ready && !rdy_prev) rdy_rise = samp;
      en_prev = LCD_EN;
      rdy_prev = Ready;
    end
  end

  task automatic clear_mon();
    obs_q.delete(); gap_q.delete(); width_q.delete(); fall_q.delete(); busy_at_q.delete();
  endtask

  task automatic wait_pulses(input int unsigned n, input int unsigned budget, output bit ok);
    int unsigned c = 0;
    while (width_q.size() < n && c < budget) begin
      @(negedge Clock);
      c++;
    end
    ok = (width_q.size() >= n);
  endtask

  // ---------------- reference model ----------------
  logic [8:0] exp_q[$];

  function automatic int unsigned wait_of(input logic [8:0] b);
    return (b == 9'h001) ? T_CLR : T_CMD;
  endfunction

  task automatic push_init();
    logic [7:0] cmds [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    foreach (cmds[i]) exp_q.push_back({1'b0, cmds[i]});
  endtask

  task automatic push_refresh(input logic [95:0] ic, input logic [2:0] mc);
    logic [7:0] c;
    exp_q.push_back({1'b0, 8'h80});
    for (int i = 11; i >= 0; i--) begin
      c = ic[8*i +: 8];
      exp_q.push_back({1'b1, (c >= 8'h20 && c <= 8'h7E) ? c : 8'h20});
    end
    exp_q.push_back({1'b0, 8'hC0});
    exp_q.push_back({1'b1, "M"});
    exp_q.push_back({1'b1, "C"});
    exp_q.push_back({1'b1, ":"});
    exp_q.push_back({1'b1, 8'h30 + {5'b0, mc}});
  endtask

  function automatic logic [95:0] rand_ic();
    logic [95:0] v;
    for (int i = 0; i < 12; i++) v[8*i +: 8] = 8'($urandom_range(0, 255));
    return v;
  endfunction

  // Release reset just after a falling edge so monitor sample n follows posedge n.
  task automatic release_reset();
    @(negedge Clock);
    #1 Reset = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    ICis = "ADD R0,R1   ";
    crtMCis = 3'd3;
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    checks++;
    if ({LCD_DATA, LCD_RS, LCD_RW, LCD_EN, LCD_ON, Ready, Busy} !== 14'h0) begin
      failures++;
      $display("FAIL reset_outputs got data=%h rs=%b rw=%b en=%b on=%b rdy=%b busy=%b want all 0",
               LCD_DATA, LCD_RS, LCD_RW, LCD_EN, LCD_ON, Ready, Busy);
    end
    clear_mon();
    exp_q.delete();
    release_reset();
    @(negedge Clock);
    checks++;
    if (LCD_ON !== 1'b1 || Ready !== 1'b0) begin
      failures++;
      $display("FAIL lcd_on_after_release got on=%b rdy=%b want on=1 rdy=0", LCD_ON, Ready);
    end
  endtask

  task automatic test_init();
    bit ok;
    push_init();
    wait_pulses(6, 2000, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL init_timeout got %0d pulses want 6", width_q.size());
      return;
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i] || width_q[i] != T_EN ||
          gap_q[i] != ((i == 0) ? T_PWRUP : wait_of(exp_q[i-1]) + 2)) begin
        failures++;
        $display("FAIL init_byte%0d got rs_data=%h w=%0d gap=%0d want %h w=%0d gap=%0d", i,
                 obs_q[i], width_q[i], gap_q[i], exp_q[i], T_EN,
                 (i == 0) ? T_PWRUP : wait_of(exp_q[i-1]) + 2);
      end
    end
    repeat (T_CMD + 3) @(negedge Clock);
    checks++;
    if (Ready !== 1'b1 || rdy_rise != fall_q[5] + T_CMD + 1) begin
      failures++;
      $display("FAIL ready_rise got rdy=%b at sample %0d want 1 at %0d", Ready, rdy_rise,
               fall_q[5] + T_CMD + 1);
    end
  endtask

  // Checks exp_q against the monitor from index 'base', including in-sequence gaps.
  task automatic test_refresh(input string name, input int unsigned base, input int unsigned n);
    bit ok;
    int unsigned bad = 0;
    wait_pulses(base + n, 3000, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_timeout got %0d pulses want %0d", name, width_q.size(), base + n);
      return;
    end
    for (int unsigned i = base; i < base + n; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i] || width_q[i] != T_EN || busy_at_q[i] !== 1'b1 ||
          ((i - base) % 18 != 0 && gap_q[i] != wait_of(exp_q[i-1]) + 2) ||
          (i > base && (i - base) % 18 == 0 && gap_q[i] != T_CMD + 4)) begin
        failures++;
        bad++;
        if (bad < 6)
          $display("FAIL %s_byte%0d got rs_data=%h w=%0d busy=%b gap=%0d want %h w=%0d busy=1",
                   name, i, obs_q[i], width_q[i], busy_at_q[i], gap_q[i], exp_q[i], T_EN);
      end
    end
    repeat (T_CMD + 4) @(negedge Clock);
    checks++;
    if (Busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_busy_end got %b want 0", name, Busy);
    end
  endtask

  task automatic test_idle_hold();
    clear_mon();
    exp_q.delete();
    repeat (1000) @(negedge Clock);
    checks++;
`ifdef AJC_LCD_ALWAYS_REFRESH_EN
    if (obs_q.size() < 18) begin
      failures++;
      $display("FAIL idle_hold got %0d pulses want continuous refresh", obs_q.size());
    end
`else
    if (obs_q.size() != 0 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_hold got %0d pulses busy=%b want 0 pulses busy=0", obs_q.size(), Busy);
    end
`endif
  endtask

  task automatic test_random(input int unsigned iters);
    logic [2:0] mc;
    for (int unsigned k = 0; k < iters; k++) begin
      clear_mon();
      exp_q.delete();
      mc = 3'($urandom_range(0, 7));
      ICis = rand_ic();
      crtMCis = mc;
      push_refresh(ICis, mc);
      test_refresh("random", 0, 18);
      repeat (100) @(negedge Clock);
      checks++;
      if (obs_q.size() != 18) begin
        failures++;
        $display("FAIL random_no_extra got %0d pulses want 18", obs_q.size());
      end
    end
  endtask

  task automatic test_nonprintable();
    clear_mon();
    exp_q.delete();
    ICis = {8'h07, "A", 8'h80, 8'h1F, 8'h20, 8'h7E, 8'h7F, 8'hFF, "z", "0", 8'h00, "~"};
    crtMCis = 3'd0;
    push_refresh(ICis, crtMCis);
    test_refresh("nonprint", 0, 18);
  endtask

  task automatic test_midchange();
    int unsigned c = 0;
    clear_mon();
    exp_q.delete();
    ICis = "ADD R0,R1   ";
    crtMCis = 3'd3;
    push_refresh(ICis, 3'd3);
    push_refresh(ICis, 3'd5);
    while (obs_q.size() < 7 && c < 2000) begin
      @(negedge Clock);
      c++;
    end
    crtMCis = 3'd5;
    test_refresh("midchange", 0, 36);
    repeat (200) @(negedge Clock);
    checks++;
    if (obs_q.size() != 36) begin
      failures++;
      $display("FAIL midchange_no_extra got %0d pulses want 36", obs_q.size());
    end
  endtask

  task automatic test_reset_midbyte();
    int unsigned c = 0;
    crtMCis = crtMCis + 3'd1;
    while (LCD_EN !== 1'b1 && c < 2000) begin
      @(negedge Clock);
      c++;
    end
    #1 Reset = 1'b0;
    #1;
    checks++;
    if (LCD_EN !== 1'b0 || Ready !== 1'b0 || LCD_ON !== 1'b0 || c >= 2000) begin
      failures++;
      $display("FAIL reset_midbyte got en=%b rdy=%b on=%b waited=%0d want 0 0 0", LCD_EN, Ready,
               LCD_ON, c);
    end
    repeat (3) @(negedge Clock);
    clear_mon();
    exp_q.delete();
    release_reset();
    test_init();
    push_refresh(ICis, crtMCis);
    test_refresh("post_reset", 6, 18);
  endtask

  initial begin
    rw_bad = 0;
    unstable = 0;
    test_reset();
    test_init();
    push_refresh(ICis, crtMCis);
    test_refresh("first", 6, 18);
    test_idle_hold();
    test_random(4);
    test_nonprintable();
    test_midchange();
    test_reset_midbyte();
    checks++;
    if (unstable != 0 || rw_bad != 0) begin
      failures++;
      $display("FAIL bus_stability got unstable=%0d rw_high=%0d want 0 0", unstable, rw_bad);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
